// File: rtl/queue_wr_arbiter.sv
// queue_wr_arbiter: round-robin arbiter that shares one queue write port among NREQ producers.
// Define QARB_PRIO0_EN to give requester 0 fixed priority over the round-robin.
module queue_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data,
    input  logic              full,
    input  logic              q_rd,
    input  logic              empty,
    output logic [NREQ-1:0]   gnt,
    output logic              q_wr,
    output logic [W-1:0]      q_din,
    output logic [CW-1:0]     level
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] NREQ_X  = (PW + 1)'(NREQ);
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] rotated;
    logic [W-1:0]    data_arr [NREQ];
    logic [CW:0]     committed;
    logic            write_ok;
    logic            rd_take;
    logic            win_found;
    logic            prio0_win;
    logic [PW:0]     cand;
    logic [PW:0]     ptr_next_x;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   ptr_next;
    logic [CW-1:0]   level_next;

    // The in-flight write is counted so a back-to-back grant cannot overrun the queue.
    assign eligible  = req & ~gnt;
    assign committed = {1'b0, level} + (CW + 1)'(q_wr);
    assign write_ok  = (committed < DEPTH_X) && !full;
    assign rd_take   = q_rd & ~empty;
    assign rotated   = NREQ'({eligible, eligible} >> ptr);

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            data_arr[i] = data[i*W +: W];
        end
    end

    // Bit j of rotated is requester (ptr+j) mod NREQ; the lowest set bit wins.
    always_comb begin
        win_found = 1'b0;
        prio0_win = 1'b0;
        cand      = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (rotated[j]) begin
                win_found = 1'b1;
                cand      = {1'b0, ptr} + (PW + 1)'(j);
            end
        end
        if (cand >= NREQ_X) begin
            cand = cand - NREQ_X;
        end
        win_idx = cand[PW-1:0];
`ifdef QARB_PRIO0_EN
        if (eligible[0]) begin
            win_found = 1'b1;
            prio0_win = 1'b1;
            win_idx   = '0;
        end
`endif
        ptr_next_x = {1'b0, win_idx} + (PW + 1)'(1);
        if (ptr_next_x >= NREQ_X) begin
            ptr_next_x = '0;
        end
        ptr_next = ptr_next_x[PW-1:0];
    end

    always_comb begin
        level_next = level;
        if (q_wr && !rd_take) begin
            if ({1'b0, level} < DEPTH_X) begin
                level_next = level + CW'(1);
            end
        end else if (!q_wr && rd_take) begin
            if (level != '0) begin
                level_next = level - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt   <= '0;
            q_wr  <= 1'b0;
            q_din <= '0;
            level <= '0;
            ptr   <= '0;
        end else begin
            level <= level_next;
            if (write_ok && win_found) begin
                gnt   <= NREQ'(1) << win_idx;
                q_wr  <= 1'b1;
                q_din <= data_arr[win_idx];
                if (!prio0_win) begin
                    ptr <= ptr_next;
                end
            end else begin
                gnt  <= '0;
                q_wr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Testbench for queue_wr_arbiter: directed scenarios plus randomized traffic checked
// every cycle against a behavioural model of the arbiter and of the attached queue.
module tb_queue_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] data;
    logic              full;
    logic              q_rd;
    logic              empty;
    logic [NREQ-1:0]   gnt;
    logic              q_wr;
    logic [W-1:0]      q_din;
    logic [CW-1:0]     level;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: expected registered outputs, pointer, and the real queue's occupancy.
    logic [NREQ-1:0] m_gnt  = '0;
    logic            m_qwr  = 1'b0;
    logic [W-1:0]    m_qdin = '0;
    int              m_level = 0;
    int              m_ptr   = 0;
    int              qcount  = 0;

    always #5 clk = ~clk;

    queue_wr_arbiter #(.NREQ(NREQ), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .data  (data),
        .full  (full),
        .q_rd  (q_rd),
        .empty (empty),
        .gnt   (gnt),
        .q_wr  (q_wr),
        .q_din (q_din),
        .level (level)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  e, win, nl, dec;
        bit  found, prio, allowed;
        if (reset) begin
            m_gnt = '0; m_qwr = 1'b0; m_qdin = '0;
            m_level = 0; m_ptr = 0; qcount = 0;
            return;
        end
        dec     = (q_rd && !empty) ? 1 : 0;
        allowed = ((m_level + int'(m_qwr)) < DEPTH) && !full;
        e       = int'(req & ~m_gnt);
        found = 1'b0; prio = 1'b0; win = 0;
`ifdef QARB_PRIO0_EN
        if ((e & 1) != 0) begin
            found = 1'b1; prio = 1'b1; win = 0;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (!found && ((e >> idx) & 1) != 0) begin
                found = 1'b1;
                win   = idx;
            end
        end
        nl = m_level + int'(m_qwr) - dec;
        if (nl > DEPTH) nl = DEPTH;
        if (nl < 0) nl = 0;
        if (m_qwr && !full) qcount++;
        qcount -= dec;
        if (allowed && found) begin
            m_gnt  = NREQ'(1 << win);
            m_qwr  = 1'b1;
            m_qdin = W'(data >> (win * W));
            if (!prio) m_ptr = (win + 1) % NREQ;
        end else begin
            m_gnt = '0;
            m_qwr = 1'b0;
        end
        m_level = nl;
    endtask

    task automatic check_output(input string ctx);
        check_val({ctx, ".gnt"},     32'(gnt),        32'(m_gnt));
        check_val({ctx, ".q_wr"},    32'(q_wr),       32'(m_qwr));
        check_val({ctx, ".q_din"},   32'(q_din),      32'(m_qdin));
        check_val({ctx, ".level"},   32'(level),      32'(m_level));
        check_val({ctx, ".wr_full"}, 32'(q_wr & full), 32'(0));
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        #1;
        full  = (qcount >= DEPTH);
        empty = (qcount == 0);
        check_output(ctx);
    endtask

    // Requesters hold until their grant is seen, then drop or re-request with fresh data.
    task automatic apply_stimulus(input int rd_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && m_gnt[i]) begin
                if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                else data[i*W +: W] = W'($urandom);
            end else if (!req[i] && $urandom_range(99, 0) < 40) begin
                req[i] = 1'b1;
                data[i*W +: W] = W'($urandom);
            end
        end
        q_rd  = ($urandom_range(99, 0) < rd_pct);
        reset = ($urandom_range(299, 0) == 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not complete, observed running expected done");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int fair_seq [8];
        int rd_pct;
`ifdef QARB_PRIO0_EN
        fair_seq = '{0, 1, 0, 2, 0, 3, 0, 1};
`else
        fair_seq = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        reset = 1'b1; req = '0; data = '0; q_rd = 1'b0; full = 1'b0; empty = 1'b1;

        step("rst0");
        step("rst1");
        check_val("rst.q_din", 32'(q_din), 32'h0);
        check_val("rst.level", 32'(level), 32'h0);
        reset = 1'b0;
        step("idle0");
        step("idle1");

        $display("[TB] single requester");
        req  = 4'b0010;
        data = 32'h3322_0A11;
        for (int s = 1; s <= 6; s++) begin
            step("single");
            if (s % 2 == 1) begin
                check_val("single.gnt", 32'(gnt), 32'h2);
                check_val("single.q_din", 32'(q_din), 32'h0A);
            end
        end
        check_val("single.level3", 32'(level), 32'd3);
        req = '0;

        $display("[TB] fairness and fill");
        reset = 1'b1;
        step("fair.rst");
        reset = 1'b0;
        req  = 4'hF;
        data = 32'h1312_1110;
        for (int k = 0; k < 8; k++) begin
            step("fair");
            check_val("fair.order", 32'(gnt), 32'(1 << fair_seq[k]));
        end
        step("fair.full0");
        check_val("fair.full0.q_wr", 32'(q_wr), 32'h0);
        check_val("fair.full0.level", 32'(level), 32'd8);
        step("fair.full1");
        check_val("fair.full1.q_wr", 32'(q_wr), 32'h0);

        $display("[TB] drain and refill");
        q_rd = 1'b1;
        step("drain");
        q_rd = 1'b0;
        check_val("drain.level", 32'(level), 32'd7);
        check_val("drain.q_wr", 32'(q_wr), 32'h0);
        step("refill");
        check_val("refill.q_wr", 32'(q_wr), 32'h1);
        step("refill.done");
        check_val("refill.level", 32'(level), 32'd8);
        check_val("refill.q_wr0", 32'(q_wr), 32'h0);

        $display("[TB] simultaneous read and write");
        reset = 1'b1;
        step("rw.rst");
        reset = 1'b0;
        for (int s = 0; s < 6; s++) step("rw.fill");
        check_val("rw.pre.level", 32'(level), 32'd5);
        check_val("rw.pre.q_wr", 32'(q_wr), 32'h1);
        q_rd = 1'b1;
        step("rw.both");
        check_val("rw.both.level", 32'(level), 32'd5);
        req   = '0;
        empty = 1'b1;
        step("rw.empty_rd");
        check_val("rw.empty_rd.level", 32'(level), 32'd6);
        q_rd = 1'b0;
        step("rw.idle");

        $display("[TB] reset mid-operation");
        req = 4'hF;
        step("midrst.run0");
        step("midrst.run1");
        reset = 1'b1;
        step("midrst.rst");
        check_val("midrst.q_wr", 32'(q_wr), 32'h0);
        check_val("midrst.level", 32'(level), 32'h0);
        reset = 1'b0;
        step("midrst.after");
        check_val("midrst.ptr0", 32'(gnt), 32'h1);

        $display("[TB] randomized traffic");
        req = '0;
        for (int c = 0; c < 600; c++) begin
            case ((c / 60) % 3)
                0:       rd_pct = 0;
                1:       rd_pct = 25;
                default: rd_pct = 60;
            endcase
            apply_stimulus(rd_pct);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
